// File: rtl/dvfs_level_sequencer.sv
// DVFS level sequencer: steps regulator and PLL between operating points
// so that the voltage level is never below the frequency level.
module dvfs_level_sequencer #(
   parameter int NUM_LEVELS       = 8,
   parameter int V_SETTLE_CYCLES  = 16,
   parameter int PLL_BLANK_CYCLES = 2,
   parameter int PLL_TIMEOUT      = 64,
   localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [LW-1:0] req_level,
   output logic [LW-1:0] volt_level,
   output logic [LW-1:0] freq_level,
   input  logic          pll_locked,
   output logic          busy,
   output logic          done,
   output logic [7:0]    status
);

   localparam logic [7:0] STATUS_OK    = 8'h00;
   localparam logic [7:0] STATUS_BUSY  = 8'h01;
   localparam logic [7:0] STATUS_ERROR = 8'hFF;

   localparam int F_SPAN = PLL_BLANK_CYCLES + PLL_TIMEOUT;
   localparam int CMAX   = (V_SETTLE_CYCLES > F_SPAN) ?
                           V_SETTLE_CYCLES : F_SPAN;
   localparam int CW     = $clog2(CMAX + 1);

   localparam logic [CW-1:0] V_LOAD  = CW'(V_SETTLE_CYCLES);
   localparam logic [CW-1:0] F_BLANK = CW'(PLL_BLANK_CYCLES);
   localparam logic [CW-1:0] F_LAST  = CW'(F_SPAN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_V_UP,
      S_F_UP,
      S_F_DN,
      S_V_DN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] volt_q, volt_d;
   logic [LW-1:0] freq_q, freq_d;
   logic [LW-1:0] tgt_q, tgt_d;
   logic [LW-1:0] old_q, old_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    status_q, status_d;

   // Next-state logic; the current operating point is the frequency level,
   // since a failed raise can leave the voltage parked above it.
   always_comb begin
      state_d  = state_q;
      volt_d   = volt_q;
      freq_d   = freq_q;
      tgt_d    = tgt_q;
      old_d    = old_q;
      cnt_d    = cnt_q;
      status_d = status_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               tgt_d = req_level;
               old_d = freq_q;
               cnt_d = '0;
               if (int'(req_level) >= NUM_LEVELS) begin
                  state_d  = S_DONE;
                  status_d = STATUS_ERROR;
               end else if (req_level == freq_q) begin
                  state_d  = S_DONE;
                  status_d = STATUS_OK;
               end else if (req_level > freq_q) begin
                  volt_d   = req_level;
                  cnt_d    = V_LOAD;
                  state_d  = S_V_UP;
                  status_d = STATUS_BUSY;
               end else begin
                  freq_d   = req_level;
                  state_d  = S_F_DN;
                  status_d = STATUS_BUSY;
               end
            end
         end
         S_V_UP: begin
            if (cnt_q <= CW'(1)) begin
               freq_d  = tgt_q;
               cnt_d   = '0;
               state_d = S_F_UP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_F_UP, S_F_DN: begin
            if ((cnt_q >= F_BLANK) && pll_locked) begin
               if (state_q == S_F_UP) begin
                  cnt_d    = '0;
                  state_d  = S_DONE;
                  status_d = STATUS_OK;
               end else begin
                  volt_d  = tgt_q;
                  cnt_d   = V_LOAD;
                  state_d = S_V_DN;
               end
            end else if (cnt_q >= F_LAST) begin
               freq_d   = old_q;
               cnt_d    = '0;
               state_d  = S_DONE;
               status_d = STATUS_ERROR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_V_DN: begin
            if (cnt_q <= CW'(1)) begin
               cnt_d    = '0;
               state_d  = S_DONE;
               status_d = STATUS_OK;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and level registers with synchronous reset that aborts any sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         volt_q   <= '0;
         freq_q   <= '0;
         tgt_q    <= '0;
         old_q    <= '0;
         cnt_q    <= '0;
         status_q <= STATUS_OK;
      end else begin
         state_q  <= state_d;
         volt_q   <= volt_d;
         freq_q   <= freq_d;
         tgt_q    <= tgt_d;
         old_q    <= old_d;
         cnt_q    <= cnt_d;
         status_q <= status_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign volt_level = volt_q;
   assign freq_level = freq_q;
   assign status     = status_q;

endmodule

// File: tb/tb_dvfs_level_sequencer.sv
// Bench for dvfs_level_sequencer: directed steps plus random requests,
// checked per cycle against a timeline model of each level change.
module tb_dvfs_level_sequencer;

   // Six levels on a 3-bit bus leaves codes 6 and 7 out of range.
   localparam int NL = 6;
   localparam int VS = 16;
   localparam int BL = 2;
   localparam int TO = 64;
   localparam int LW = 3;

   localparam logic [7:0] OK   = 8'h00;
   localparam logic [7:0] BSY  = 8'h01;
   localparam logic [7:0] ERR  = 8'hFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [LW-1:0] req_level = '0;
   logic          pll_locked = 1'b0;
   logic          req_ready;
   logic [LW-1:0] volt_level;
   logic [LW-1:0] freq_level;
   logic          busy;
   logic          done;
   logic [7:0]    status;

   always #5 clk = ~clk;

   dvfs_level_sequencer #(
      .NUM_LEVELS      (NL),
      .V_SETTLE_CYCLES (VS),
      .PLL_BLANK_CYCLES(BL),
      .PLL_TIMEOUT     (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_level (req_level),
      .volt_level(volt_level),
      .freq_level(freq_level),
      .pll_locked(pll_locked),
      .busy      (busy),
      .done      (done),
      .status    (status)
   );

   int checks = 0;
   int errors = 0;

   logic [LW-1:0] mv = '0;
   logic [LW-1:0] mf = '0;
   logic [7:0]    mst = OK;

   bit            lockv [0:255];
   logic [LW-1:0] ev    [0:255];
   logic [LW-1:0] ef    [0:255];
   logic [7:0]    es    [0:255];
   int            dur;

   function automatic logic [16:0] pack(input logic [LW-1:0] v,
                                        input logic [LW-1:0] f,
                                        input logic d, input logic b,
                                        input logic r,
                                        input logic [7:0] s);
      return {v, f, d, b, r, s};
   endfunction

   function automatic logic [16:0] obs();
      return pack(volt_level, freq_level, done, busy, req_ready, status);
   endfunction

   task automatic chk(input string tag, input logic [16:0] got,
                      input logic [16:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_inv(input string tag);
      checks++;
      assert ((volt_level >= freq_level) === 1'b1) else begin
         errors++;
         $error("FAIL %s_inv volt=%0d freq=%0d", tag, volt_level, freq_level);
      end
   endtask

   // mode 0: always locked, 1: never, 2: sparse random, 3: single pulse at idx
   task automatic set_lock(input int mode, input int idx);
      for (int i = 0; i < 256; i++) begin
         unique case (mode)
            0:       lockv[i] = 1'b1;
            1:       lockv[i] = 1'b0;
            2:       lockv[i] = ($urandom_range(0, 7) == 0);
            default: lockv[i] = (i == idx);
         endcase
      end
   endtask

   // Timeline of a request: obs index k is the cycle after the k-th edge
   // counted from the accept edge; lockv[k] is the lock level in that cycle.
   task automatic build(input int lvl);
      int hit;
      hit = 0;
      if (lvl >= NL || lvl == int'(mf)) begin
         dur   = 0;
         ev[0] = mv;
         ef[0] = mf;
         es[0] = (lvl >= NL) ? ERR : OK;
      end else if (lvl > int'(mf)) begin
         for (int j = VS + BL + 1; j <= VS + BL + TO; j++)
            if (hit == 0 && lockv[j-1]) hit = j;
         dur = (hit != 0) ? hit : VS + BL + TO;
         for (int k = 0; k <= dur; k++) begin
            ev[k] = LW'(lvl);
            ef[k] = (k < VS) ? mf : LW'(lvl);
            es[k] = BSY;
         end
         if (hit == 0) ef[dur] = mf;
         es[dur] = (hit != 0) ? OK : ERR;
      end else begin
         for (int j = BL + 1; j <= BL + TO; j++)
            if (hit == 0 && lockv[j-1]) hit = j;
         dur = (hit != 0) ? hit + VS : BL + TO;
         for (int k = 0; k <= dur; k++) begin
            ef[k] = LW'(lvl);
            ev[k] = (hit != 0 && k >= hit) ? LW'(lvl) : mv;
            es[k] = BSY;
         end
         if (hit == 0) ef[dur] = mf;
         es[dur] = (hit != 0) ? OK : ERR;
      end
      mv  = ev[dur];
      mf  = ef[dur];
      mst = es[dur];
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge, idle.
   task automatic run_txn(input int lvl, input string tag);
      build(lvl);
      req_valid = 1'b1;
      req_level = LW'(lvl);
      for (int k = 0; k <= dur; k++) begin
         @(negedge clk);
         req_valid  = (k < dur) ? 1'($urandom_range(0, 1)) : 1'b0;
         req_level  = LW'($urandom_range(0, 7));
         pll_locked = lockv[k];
         chk($sformatf("%s[%0d]", tag, k), obs(),
             pack(ev[k], ef[k], k == dur, 1'b1, 1'b0, es[k]));
         chk_inv($sformatf("%s[%0d]", tag, k));
      end
      @(negedge clk);
      chk($sformatf("%s_idle", tag), obs(),
          pack(mv, mf, 1'b0, 1'b0, 1'b1, mst));
   endtask

   initial begin
      // reset and idle
      repeat (3) @(negedge clk);
      chk("reset", obs(), pack(0, 0, 0, 0, 1, OK));
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("idle[%0d]", i), obs(), pack(0, 0, 0, 0, 1, OK));
      end

      set_lock(0, 0);
      run_txn(5, "raise_0_5");
      run_txn(2, "lower_5_2");
      set_lock(1, 0);
      run_txn(5, "raise_timeout");
      run_txn(6, "invalid_6");
      run_txn(7, "invalid_7");
      run_txn(2, "equal_2");
      set_lock(0, 0);
      run_txn(1, "lower_v5_1");
      set_lock(1, 0);
      lockv[VS]     = 1'b1;
      lockv[VS + 1] = 1'b1;
      run_txn(3, "lock_in_blank");
      set_lock(3, VS + BL + TO - 1);
      run_txn(4, "lock_last");
      set_lock(3, BL);
      run_txn(0, "lock_first");
      set_lock(0, 0);
      run_txn(5, "raise_0_5b");
      set_lock(1, 0);
      run_txn(3, "lower_timeout");

      // reset during V_UP
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mv  = '0;
      mf  = '0;
      mst = OK;
      req_valid = 1'b1;
      req_level = 3'd4;
      @(negedge clk);
      req_valid = 1'b0;
      chk("vup_0_4", obs(), pack(4, 0, 0, 1, 0, BSY));
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid", obs(), pack(0, 0, 0, 0, 1, OK));
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_nodone", obs(), pack(0, 0, 0, 0, 1, OK));
      set_lock(0, 0);
      run_txn(4, "after_rst");

      for (int n = 0; n < 40; n++) begin
         set_lock($urandom_range(0, 3), $urandom_range(0, 90));
         run_txn($urandom_range(0, 7), $sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
